// File: rtl/indexed_lsh_buf.sv
// Indexed left-shift deletion buffer: remove any slot with a single-cycle compaction, append at the tail.
// Optional macro IDX_LSH_ZERO_FILL_EN clears the slot vacated by a remove.
module indexed_lsh_buf #(
    parameter int data_width_param = 32,
    parameter int idx_width_param  = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        ld_valid,
    input  logic [data_width_param-1:0] ld_data,
    output logic                        ld_ready,
    input  logic                        rm_valid,
    input  logic [idx_width_param-1:0]  rm_idx,
    output logic                        rm_ready,
    output logic                        out_valid,
    output logic [data_width_param-1:0] out_data,
    output logic                        out_err,
    input  logic                        out_ready,
    output logic [idx_width_param:0]    count,
    input  logic [idx_width_param-1:0]  peek_idx,
    output logic [data_width_param-1:0] peek_data
);

    localparam int depth_param = 2 ** idx_width_param;

    typedef enum logic {
        IDLE,
        RESP
    } state_t;

    state_t                      state;
    state_t                      state_next;
    logic [data_width_param-1:0] arr      [depth_param];
    logic [data_width_param-1:0] arr_next [depth_param];
    logic [idx_width_param:0]    count_next;
    logic [idx_width_param:0]    count_m1;
    logic [idx_width_param-1:0]  wr_idx;
    logic                        ld_fire;
    logic                        rm_fire;
    logic                        rm_hit;

    assign ld_ready  = (count != (idx_width_param + 1)'(depth_param));
    assign rm_ready  = !out_valid || out_ready;
    assign ld_fire   = ld_valid && ld_ready;
    assign rm_fire   = rm_valid && rm_ready;
    assign rm_hit    = rm_fire && ({1'b0, rm_idx} < count);
    assign count_m1  = count - (idx_width_param + 1)'(1);
    assign out_valid = (state == RESP);
    assign peek_data = arr[peek_idx];

    // A paired append lands in the slot the remove just freed, so count stays put.
    assign wr_idx = rm_hit ? count_m1[idx_width_param-1:0] : count[idx_width_param-1:0];

    always_comb begin
        arr_next   = arr;
        count_next = count;
        if (rm_hit) begin
            for (int k = 0; k < depth_param - 1; k++) begin
                if ((k >= int'(rm_idx)) && (k < int'(count) - 1)) begin
                    arr_next[k] = arr[k+1];
                end
            end
`ifdef IDX_LSH_ZERO_FILL_EN
            arr_next[count_m1[idx_width_param-1:0]] = '0;
`endif
            count_next = count_m1;
        end
        if (ld_fire) begin
            arr_next[wr_idx] = ld_data;
            count_next       = count_next + (idx_width_param + 1)'(1);
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (rm_fire) state_next = RESP;
            RESP: if (out_ready && !rm_fire) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < depth_param; k++) begin
                arr[k] <= '0;
            end
            count <= '0;
        end else begin
            arr   <= arr_next;
            count <= count_next;
        end
    end

    // Response payload only reloads on an accepted remove, so it holds while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            out_data <= '0;
            out_err  <= 1'b0;
        end else begin
            state <= state_next;
            if (rm_fire) begin
                out_data <= rm_hit ? arr[rm_idx] : '0;
                out_err  <= !rm_hit;
            end
        end
    end

endmodule

// File: tb/tb_indexed_lsh_buf.sv
// Scoreboard bench for indexed_lsh_buf; honours IDX_LSH_ZERO_FILL_EN for vacated-slot contents.
module tb_indexed_lsh_buf;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } resp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ld_valid = 1'b0;
    logic [31:0] ld_data = '0;
    logic        ld_ready;
    logic        rm_valid = 1'b0;
    logic [3:0]  rm_idx = '0;
    logic        rm_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_err;
    logic        out_ready = 1'b1;
    logic [4:0]  count;
    logic [3:0]  peek_idx = '0;
    logic [31:0] peek_data;

    int          total = 0;
    int          bad = 0;
    logic [31:0] m_arr [16];
    int          m_cnt = 0;
    logic        m_ov = 1'b0;
    resp_t       sb [$];

    indexed_lsh_buf #(.data_width_param(32), .idx_width_param(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
        .rm_valid(rm_valid), .rm_idx(rm_idx), .rm_ready(rm_ready),
        .out_valid(out_valid), .out_data(out_data), .out_err(out_err), .out_ready(out_ready),
        .count(count), .peek_idx(peek_idx), .peek_data(peek_data)
    );

    always #20 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < 16; i++) m_arr[i] = '0;
        m_cnt = 0;
        m_ov  = 1'b0;
        sb.delete();
    endtask

    // One clock of stimulus: drive at negedge, check handshakes/response, advance model, check count.
    task automatic applyStimulus(input logic ldv, input logic [31:0] ldd, input logic rmv,
                                 input logic [3:0] rmi, input logic outr);
        logic  exp_ldr, exp_rmr, rm_f, ld_f;
        resp_t r;
        @(negedge clk);
        ld_valid = ldv; ld_data = ldd; rm_valid = rmv; rm_idx = rmi; out_ready = outr;
        #1;
        exp_ldr = (m_cnt != 16);
        exp_rmr = !m_ov || outr;
        checkOutput("ld_ready", ld_ready, exp_ldr);
        checkOutput("rm_ready", rm_ready, exp_rmr);
        checkOutput("out_valid", out_valid, m_ov);
        if (m_ov) begin
            if (sb.size() == 0) begin
                checkOutput("sb_empty", 1, 0);
            end else begin
                checkOutput("out_data", out_data, sb[0].data);
                checkOutput("out_err", out_err, sb[0].err);
                if (outr) void'(sb.pop_front());
            end
        end
        rm_f = rmv && exp_rmr;
        ld_f = ldv && exp_ldr;
        if (rm_f) begin
            if (int'(rmi) < m_cnt) begin
                r.data = m_arr[rmi]; r.err = 1'b0;
                for (int k = int'(rmi); k < m_cnt - 1; k++) m_arr[k] = m_arr[k+1];
`ifdef IDX_LSH_ZERO_FILL_EN
                m_arr[m_cnt-1] = '0;
`endif
                m_cnt--;
            end else begin
                r.data = '0; r.err = 1'b1;
            end
            sb.push_back(r);
        end
        if (ld_f) begin
            m_arr[m_cnt] = ldd;
            m_cnt++;
        end
        if (rm_f) m_ov = 1'b1;
        else if (outr) m_ov = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("count", count, m_cnt);
    endtask

    task automatic checkSlots();
        for (int i = 0; i < m_cnt; i++) begin
            peek_idx = 4'(i);
            #1;
            checkOutput($sformatf("peek%0d", i), peek_data, m_arr[i]);
        end
    endtask

    task automatic idle(input logic outr);
        applyStimulus(1'b0, 32'd0, 1'b0, 4'd0, outr);
    endtask

    initial begin
        modelReset();
        #5;
        checkOutput("rst_count", count, 0);
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_out_data", out_data, 0);
        checkOutput("rst_out_err", out_err, 0);
        checkOutput("rst_ld_ready", ld_ready, 1);
        checkOutput("rst_rm_ready", rm_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;

        // Append 10..40 then remove slot 1.
        for (int i = 1; i <= 4; i++) applyStimulus(1'b1, 32'(10 * i), 1'b0, 4'd0, 1'b1);
        checkOutput("count4", count, 4);
        checkSlots();
        applyStimulus(1'b0, 32'd0, 1'b1, 4'd1, 1'b1);
        checkSlots();
        peek_idx = 4'd3;
        #1;
`ifdef IDX_LSH_ZERO_FILL_EN
        checkOutput("vacated_slot", peek_data, 0);
`else
        checkOutput("vacated_slot", peek_data, 40);
`endif
        idle(1'b1);

        // Out-of-range remove, then remove-last with same-cycle append.
        applyStimulus(1'b0, 32'd0, 1'b1, 4'd5, 1'b1);
        idle(1'b1);
        checkSlots();
        applyStimulus(1'b1, 32'd77, 1'b1, 4'd2, 1'b1);
        checkSlots();
        peek_idx = 4'd2;
        #1;
        checkOutput("slot2_77", peek_data, 77);
        idle(1'b1);

        // Stalled response, blocked second remove, then handoff.
        applyStimulus(1'b0, 32'd0, 1'b1, 4'd0, 1'b0);
        applyStimulus(1'b0, 32'd0, 1'b1, 4'd0, 1'b0);
        applyStimulus(1'b0, 32'd0, 1'b1, 4'd1, 1'b0);
        idle(1'b1);
        idle(1'b1);

        // Reset asserted while a response is pending.
        applyStimulus(1'b0, 32'd0, 1'b1, 4'd0, 1'b0);
        @(negedge clk);
        rm_valid = 1'b0; out_ready = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_out_valid", out_valid, 0);
        checkOutput("mid_rst_out_data", out_data, 0);
        checkOutput("mid_rst_out_err", out_err, 0);
        checkOutput("mid_rst_count", count, 0);
        checkOutput("mid_rst_rm_ready", rm_ready, 1);
        modelReset();
        @(negedge clk);
        rst_n = 1'b1;

        // Fill to full, rejected append, remove 0 + append 99.
        for (int i = 0; i < 16; i++) applyStimulus(1'b1, 32'(i), 1'b0, 4'd0, 1'b1);
        applyStimulus(1'b1, 32'd99, 1'b0, 4'd0, 1'b1);
        applyStimulus(1'b1, 32'd99, 1'b1, 4'd0, 1'b1);
        checkOutput("count15", count, 15);
        peek_idx = 4'd0;
        #1;
        checkOutput("slot0_1", peek_data, 1);
        checkSlots();

        // Back-to-back removes, then random traffic.
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 32'd0, 1'b1, 4'(i * 3), 1'b1);
        for (int i = 0; i < 80; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
                          4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0));
            checkSlots();
        end
        idle(1'b1);
        idle(1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
